// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - Shared FSM state encoding and forwarding-unit code constants for hazard_ctrl
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEMWAIT  = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

    localparam logic [2:0] FWD_NONE    = 3'd0;
    localparam logic [2:0] FWD_EXMA1   = 3'd1;
    localparam logic [2:0] FWD_EXMA2   = 3'd2;
    localparam logic [2:0] FWD_EXMA3   = 3'd3;
    localparam logic [2:0] FWD_MAWB    = 3'd4;
    localparam logic [2:0] FWD_LOADUSE = 3'd5;

    function automatic logic is_load_use(input logic [2:0] code, input logic used);
        return used && (code == FWD_LOADUSE);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - Three saturating event counters (load-use bubbles, redirects, mem-wait cycles)
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ld_stall_inc,
    input  logic             flush_inc,
    input  logic             mem_wait_inc,
    output logic [CNT_W-1:0] ld_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    logic [CNT_W-1:0] ld_stall_q, ld_stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] mem_wait_q, mem_wait_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        ld_stall_d = sat_inc(ld_stall_q, ld_stall_inc);
        flush_d    = sat_inc(flush_q, flush_inc);
        mem_wait_d = sat_inc(mem_wait_q, mem_wait_inc);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ld_stall_q <= '0;
            flush_q    <= '0;
            mem_wait_q <= '0;
        end else begin
            ld_stall_q <= ld_stall_d;
            flush_q    <= flush_d;
            mem_wait_q <= mem_wait_d;
        end
    end

    assign ld_stall_cnt = ld_stall_q;
    assign flush_cnt    = flush_q;
    assign mem_wait_cnt = mem_wait_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Pipeline stall/flush/freeze controller; HZD_PERF_CNT_EN adds perf counter outputs
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef HZD_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] fwd1In,
    input  logic [2:0] fwd2In,
    input  logic       IDEXuseRs1In,
    input  logic       IDEXuseRs2In,
    input  logic       branchTakenIn,
    input  logic       dmemReqIn,
    input  logic       dmemReadyIn,
    output logic       pcWriteOut,
    output logic       pcRedirectOut,
    output logic       IFIDwriteOut,
    output logic       IDEXwriteOut,
    output logic       EXMAwriteOut,
    output logic       IFIDflushOut,
    output logic       IDEXflushOut,
    output logic       EXMAflushOut,
    output logic       errOut,
    output logic [1:0] stateOut
`ifdef HZD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] ldStallCntOut,
    output logic [CNT_W-1:0] flushCntOut,
    output logic [CNT_W-1:0] memWaitCntOut
`endif
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_MAX = TW'(MEM_TIMEOUT - 1);

    hz_state_e state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d;
    logic err_q, err_d;

    logic load_use, mem_stall;

    assign load_use  = is_load_use(fwd1In, IDEXuseRs1In) || is_load_use(fwd2In, IDEXuseRs2In);
    assign mem_stall = dmemReqIn && !dmemReadyIn;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        err_d   = err_q;

        pcWriteOut    = 1'b1;
        pcRedirectOut = 1'b0;
        IFIDwriteOut  = 1'b1;
        IDEXwriteOut  = 1'b1;
        EXMAwriteOut  = 1'b1;
        IFIDflushOut  = 1'b0;
        IDEXflushOut  = 1'b0;
        EXMAflushOut  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    {pcWriteOut, IFIDwriteOut, IDEXwriteOut, EXMAwriteOut} = '0;
                    pend_d  = branchTakenIn;
                    cnt_d   = '0;
                    state_d = ST_MEMWAIT;
                end else if (load_use) begin
                    // Branch outcome is computed from a stale operand here, so it is dropped.
                    {pcWriteOut, IFIDwriteOut, IDEXwriteOut} = '0;
                    EXMAflushOut = 1'b1;
                end else if (branchTakenIn) begin
                    pcRedirectOut = 1'b1;
                    IFIDflushOut  = 1'b1;
                    IDEXflushOut  = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (dmemReadyIn) begin
                    cnt_d   = '0;
                    state_d = pend_q ? ST_REDIRECT : ST_RUN;
                end else begin
                    {pcWriteOut, IFIDwriteOut, IDEXwriteOut, EXMAwriteOut} = '0;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) err_d = 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (mem_stall) begin
                    {pcWriteOut, IFIDwriteOut, IDEXwriteOut, EXMAwriteOut} = '0;
                    state_d = ST_MEMWAIT;
                end else begin
                    pcRedirectOut = 1'b1;
                    IFIDflushOut  = 1'b1;
                    IDEXflushOut  = 1'b1;
                    pend_d        = 1'b0;
                    state_d       = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (!rstn) begin
            {pcWriteOut, IFIDwriteOut, IDEXwriteOut, EXMAwriteOut} = '0;
            pcRedirectOut = 1'b0;
            {IFIDflushOut, IDEXflushOut, EXMAflushOut} = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign errOut   = err_q;
    assign stateOut = state_q;

`ifdef HZD_PERF_CNT_EN
    // EXMA flush outside reset only ever comes from a load-use bubble; redirect marks every applied branch.
    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .ld_stall_inc(rstn && EXMAflushOut),
        .flush_inc   (pcRedirectOut),
        .mem_wait_inc(rstn && (state_q == ST_MEMWAIT)),
        .ld_stall_cnt(ldStallCntOut),
        .flush_cnt   (flushCntOut),
        .mem_wait_cnt(memWaitCntOut)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - Table-driven bench for hazard_ctrl; perf counter checks under HZD_PERF_CNT_EN
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] fwd1, fwd2;
    logic       use1, use2, br, req, rdy;
    logic       pcw, redir, ifidw, idexw, exmaw, ifidf, idexf, exmaf, err;
    logic [1:0] st;
`ifdef HZD_PERF_CNT_EN
    logic [31:0] ld_cnt, fl_cnt, mw_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .fwd1In       (fwd1),
        .fwd2In       (fwd2),
        .IDEXuseRs1In (use1),
        .IDEXuseRs2In (use2),
        .branchTakenIn(br),
        .dmemReqIn    (req),
        .dmemReadyIn  (rdy),
        .pcWriteOut   (pcw),
        .pcRedirectOut(redir),
        .IFIDwriteOut (ifidw),
        .IDEXwriteOut (idexw),
        .EXMAwriteOut (exmaw),
        .IFIDflushOut (ifidf),
        .IDEXflushOut (idexf),
        .EXMAflushOut (exmaf),
        .errOut       (err),
        .stateOut     (st)
`ifdef HZD_PERF_CNT_EN
        ,
        .ldStallCntOut(ld_cnt),
        .flushCntOut  (fl_cnt),
        .memWaitCntOut(mw_cnt)
`endif
    );

    // {pcw,redir}_{ifidw,idexw,exmaw}_{ifidf,idexf,exmaf}_err_state
    localparam logic [10:0] E_RST   = 11'b00_000_111_0_00;
    localparam logic [10:0] E_RSTMW = 11'b00_000_111_0_01;
    localparam logic [10:0] E_RUN   = 11'b10_111_000_0_00;
    localparam logic [10:0] E_RUNE  = 11'b10_111_000_1_00;
    localparam logic [10:0] E_LU    = 11'b00_001_001_0_00;
    localparam logic [10:0] E_BR    = 11'b11_111_110_0_00;
    localparam logic [10:0] E_FRZ0  = 11'b00_000_000_0_00;
    localparam logic [10:0] E_FRZ1  = 11'b00_000_000_0_01;
    localparam logic [10:0] E_FRZ2  = 11'b00_000_000_0_10;
    localparam logic [10:0] E_REL   = 11'b10_111_000_0_01;
    localparam logic [10:0] E_RDR   = 11'b11_111_110_0_10;

    typedef struct {
        string       name;
        logic        rstn;
        logic [2:0]  f1;
        logic [2:0]  f2;
        logic        u1, u2, br, req, rdy;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic rn, input logic [2:0] f1, input logic [2:0] f2,
                                input logic u1, input logic u2, input logic b, input logic rq,
                                input logic rd, input logic [10:0] e);
        vec_t v;
        v.name = nm; v.rstn = rn; v.f1 = f1; v.f2 = f2; v.u1 = u1; v.u2 = u2;
        v.br = b; v.req = rq; v.rdy = rd; v.exp = e;
        return v;
    endfunction

    function automatic logic [10:0] got_o();
        return {pcw, redir, ifidw, idexw, exmaw, ifidf, idexf, exmaf, err, st};
    endfunction

    task automatic drive(input logic rn, input logic [2:0] f1, input logic [2:0] f2, input logic u1,
                         input logic u2, input logic b, input logic rq, input logic rd);
        rstn = rn; fwd1 = f1; fwd2 = f2; use1 = u1; use2 = u2; br = b; req = rq; rdy = rd;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        //            name            rn f1 f2 u1 u2 br rq rd expected
        tbl.push_back(mk("rst_a",      0, 0, 0, 0, 0, 0, 0, 0, E_RST));
        tbl.push_back(mk("rst_b",      0, 5, 5, 1, 1, 1, 1, 0, E_RST));
        tbl.push_back(mk("idle",       1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("lu_rs1",     1, 5, 0, 1, 0, 0, 0, 0, E_LU));
        tbl.push_back(mk("mawb_rs1",   1, 4, 0, 1, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("lu_rs2_nu",  1, 0, 5, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("lu_over_br", 1, 5, 0, 1, 0, 1, 0, 0, E_LU));
        tbl.push_back(mk("br_run",     1, 4, 0, 1, 0, 1, 0, 0, E_BR));
        tbl.push_back(mk("lu_rs2",     1, 0, 5, 0, 1, 0, 0, 0, E_LU));
        tbl.push_back(mk("idle2",      1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("mw_br_c1",   1, 0, 0, 0, 0, 1, 1, 0, E_FRZ0));
        tbl.push_back(mk("mw_c2",      1, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk("mw_c3",      1, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk("mw_rel",     1, 0, 0, 0, 0, 0, 1, 1, E_REL));
        tbl.push_back(mk("redirect",   1, 0, 0, 0, 0, 0, 0, 0, E_RDR));
        tbl.push_back(mk("post_rdr",   1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("mem_over_lu",1, 5, 0, 1, 0, 0, 1, 0, E_FRZ0));
        tbl.push_back(mk("rel_with_lu",1, 5, 0, 1, 0, 0, 1, 1, E_REL));
        tbl.push_back(mk("lu_after",   1, 5, 0, 1, 0, 0, 0, 0, E_LU));
        tbl.push_back(mk("mawb_after", 1, 4, 0, 1, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("mw2_br",     1, 0, 0, 0, 0, 1, 1, 0, E_FRZ0));
        tbl.push_back(mk("mw2_rel",    1, 0, 0, 0, 0, 0, 1, 1, E_REL));
        tbl.push_back(mk("rdr_stall",  1, 0, 0, 0, 0, 0, 1, 0, E_FRZ2));
        tbl.push_back(mk("mw2_rel2",   1, 0, 0, 0, 0, 0, 1, 1, E_REL));
        tbl.push_back(mk("rdr_kept",   1, 0, 0, 0, 0, 0, 0, 0, E_RDR));
        tbl.push_back(mk("post_rdr2",  1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("mw3_br",     1, 0, 0, 0, 0, 1, 1, 0, E_FRZ0));
        tbl.push_back(mk("mw3_c2",     1, 0, 0, 0, 0, 0, 1, 0, E_FRZ1));
        tbl.push_back(mk("rst_in_mw",  0, 0, 0, 0, 0, 0, 1, 0, E_RSTMW));
        tbl.push_back(mk("no_stale_br",1, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        tbl.push_back(mk("req_ready",  1, 0, 0, 0, 0, 0, 1, 1, E_RUN));

        foreach (tbl[i]) begin
            #1 drive(tbl[i].rstn, tbl[i].f1, tbl[i].f2, tbl[i].u1, tbl[i].u2, tbl[i].br, tbl[i].req, tbl[i].rdy);
            @(negedge clk);
            check(tbl[i].name, 64'(got_o()), 64'(tbl[i].exp));
            @(posedge clk);
        end

        // Timeout: one RUN freeze cycle, then 20 MEMWAIT cycles; error visible after the 16th.
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d", k), 64'(got_o()), 64'({E_FRZ1[10:3], (k > 16), 2'b01}));
            @(posedge clk);
        end
        #1 drive(1, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        check("to_release", 64'(got_o()), 64'({E_REL[10:3], 1'b1, 2'b01}));
        @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("to_sticky", 64'(got_o()), 64'(E_RUNE));
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("to_cleared", 64'(got_o()), 64'(E_RUN));
        @(posedge clk);

`ifdef HZD_PERF_CNT_EN
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 drive(1, 5, 0, 1, 0, 0, 0, 0); @(posedge clk);
        #1 drive(1, 4, 0, 1, 0, 0, 0, 0); @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 1, 0, 0); @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 1, 1, 0); @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 1, 0); @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 1, 0); @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 1, 1); @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 0, 0); @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("perf_ld", 64'(ld_cnt), 64'd1);
        check("perf_flush", 64'(fl_cnt), 64'd2);
        check("perf_memwait", 64'(mw_cnt), 64'd3);
        #1 drive(1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1 drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("perf_rst", 64'({ld_cnt, fl_cnt} | 64'(mw_cnt)), 64'd0);
        @(posedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
